// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a value source and the sequential binary-to-BCD converter.
// start is a request taken only while busy=0; done pulses once when the digits and ovf are updated.
interface bin_to_bcd_seq_if #(
    parameter int IN_W = 14
);
    logic            start;
    logic [IN_W-1:0] bin;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [3:0]      dig0;
    logic [3:0]      dig1;
    logic [3:0]      dig2;
    logic [3:0]      dig3;

    modport master (
        output start, bin,
        input  busy, done, ovf, dig0, dig1, dig2, dig3
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, dig0, dig1, dig2, dig3
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one bit per clock, feeding a 4-digit display.
// Published digits only change on the completion edge so the display never shows partial results.
module bin_to_bcd_seq #(
    parameter int IN_W = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    bin_to_bcd_seq_if.slave     bus,
    output logic                dbg_state
);
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [IN_W-1:0]   bin_sr, bin_sr_n;
    logic [15:0]       bcd, bcd_n;
    logic [15:0]       adj;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ovf_int, ovf_int_n;
    logic [15:0]       dig_r, dig_n;
    logic              ovf_r, ovf_n;
    logic              done_r, done_n;
    logic [16:0]       bin_ext;
    logic [15+IN_W:0]  shifted;

    assign bin_ext = 17'(bus.bin);

    // Add-3 correction precedes the shift so no nibble can exceed 9 after doubling.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj, bin_sr} << 1;

    always_comb begin
        state_n   = state;
        bin_sr_n  = bin_sr;
        bcd_n     = bcd;
        cnt_n     = cnt;
        ovf_int_n = ovf_int;
        dig_n     = dig_r;
        ovf_n     = ovf_r;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    // Values above 9999 cannot fit four digits; show 9999 and flag it.
                    if (bin_ext > 17'd9999) begin
                        bin_sr_n  = IN_W'(17'd9999);
                        ovf_int_n = 1'b1;
                    end else begin
                        bin_sr_n  = bus.bin;
                        ovf_int_n = 1'b0;
                    end
                    bcd_n   = 16'd0;
                    cnt_n   = CW'(IN_W);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                bcd_n    = shifted[15+IN_W -: 16];
                bin_sr_n = shifted[IN_W-1:0];
                cnt_n    = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    dig_n   = shifted[15+IN_W -: 16];
                    ovf_n   = ovf_int;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            dig_r   <= '0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            bin_sr  <= bin_sr_n;
            bcd     <= bcd_n;
            cnt     <= cnt_n;
            ovf_int <= ovf_int_n;
            dig_r   <= dig_n;
            ovf_r   <= ovf_n;
            done_r  <= done_n;
        end
    end

    assign bus.busy  = (state == SHIFT);
    assign bus.done  = done_r;
    assign bus.ovf   = ovf_r;
    assign bus.dig0  = dig_r[3:0];
    assign bus.dig1  = dig_r[7:4];
    assign bus.dig2  = dig_r[11:8];
    assign bus.dig3  = dig_r[15:12];
    assign dbg_state = state;
endmodule
